// File: rtl/axi_master_rd_burst_engine_if.sv
// -----------------------------------------------------------------------------
// axi_master_rd_burst_engine_if
// Bundles the signals of the read burst engine that face its neighbours:
//   - req_*   : command channel from the decoder (valid/ready)
//   - AR*     : AXI read address channel
//   - R*      : AXI read data channel
//   - rsp_*   : registered beat return channel to the decoder (valid/ready)
// Modports:
//   master : the view of the burst engine itself
//   slave  : the opposite view (decoder + AXI slave side, e.g. a testbench)
// -----------------------------------------------------------------------------
interface axi_master_rd_burst_engine_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
);

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [ID_W-1:0]   req_id;
  logic [7:0]        req_len;
  logic [2:0]        req_size;
  logic [1:0]        req_burst;
  logic [1:0]        req_lock;
  logic [3:0]        req_cache;
  logic [2:0]        req_prot;

  logic [ID_W-1:0]   ARID;
  logic [ADDR_W-1:0] ARADDR;
  logic [7:0]        ARLEN;
  logic [2:0]        ARSIZE;
  logic [1:0]        ARBURST;
  logic [1:0]        ARLOCK;
  logic [3:0]        ARCACHE;
  logic [2:0]        ARPROT;
  logic              ARVALID;
  logic              ARREADY;

  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic [ID_W-1:0]   RID;
  logic              RLAST;
  logic              RVALID;
  logic              RREADY;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [1:0]        rsp_resp;
  logic [ID_W-1:0]   rsp_id;
  logic              rsp_last;

  modport master (
    input  req_valid, req_addr, req_id, req_len, req_size, req_burst,
           req_lock, req_cache, req_prot,
    output req_ready,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARVALID,
    input  ARREADY,
    input  RDATA, RRESP, RID, RLAST, RVALID,
    output RREADY,
    output rsp_valid, rsp_data, rsp_resp, rsp_id, rsp_last,
    input  rsp_ready
  );

  modport slave (
    output req_valid, req_addr, req_id, req_len, req_size, req_burst,
           req_lock, req_cache, req_prot,
    input  req_ready,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARVALID,
    output ARREADY,
    output RDATA, RRESP, RID, RLAST, RVALID,
    input  RREADY,
    input  rsp_valid, rsp_data, rsp_resp, rsp_id, rsp_last,
    output rsp_ready
  );

endinterface

// File: rtl/axi_master_rd_burst_engine.sv
// -----------------------------------------------------------------------------
// axi_master_rd_burst_engine
// AXI read master control. Takes read commands from the decoder, issues them on
// the AR channel, tracks the expected beat count of every outstanding burst in
// an in-order length FIFO, and returns R beats through a one-deep registered
// output stage with back-pressure. RLAST is checked against the expected burst
// length; illegal WRAP lengths and the reserved burst type are dropped.
//
// Ports:
//   AClk        clock
//   ARst        asynchronous reset, active-low
//   bus         axi_master_rd_burst_engine_if.master (req_*, AR*, R*, rsp_*)
//   outstanding bursts issued and not yet retired
//   err_req     one-cycle pulse: illegal command dropped
//   err_rlast   sticky RLAST mismatch flag
//   err_tmo     sticky read timeout flag (only with RD_TIMEOUT_EN)
//   err_clr     clears the sticky error flags
//
// Optional feature: define RD_TIMEOUT_EN to add the TMO_CYC parameter, the
// err_tmo port and a watchdog that flushes all tracking when the R channel
// stalls for TMO_CYC cycles with bursts outstanding.
// -----------------------------------------------------------------------------
module axi_master_rd_burst_engine #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int ID_W    = 4,
  parameter int MAX_OUT = 4
`ifdef RD_TIMEOUT_EN
  , parameter int TMO_CYC = 1024
`endif
) (
  input  logic                          AClk,
  input  logic                          ARst,
  axi_master_rd_burst_engine_if.master  bus,
  output logic [4:0]                    outstanding,
  output logic                          err_req,
  output logic                          err_rlast,
`ifdef RD_TIMEOUT_EN
  output logic                          err_tmo,
`endif
  input  logic                          err_clr
);

  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t            state_q, state_d;
  logic              active_q;
  logic              load_ar, drop_cmd;
  logic              cmd_fire, cmd_bad, wrap_ok;
  logic              ar_fire;

  logic [ID_W-1:0]   ar_id_q;
  logic [ADDR_W-1:0] ar_addr_q;
  logic [7:0]        ar_len_q;
  logic [2:0]        ar_size_q;
  logic [1:0]        ar_burst_q;
  logic [1:0]        ar_lock_q;
  logic [3:0]        ar_cache_q;
  logic [2:0]        ar_prot_q;

  logic [7:0]        len_mem [MAX_OUT];
  logic [PW-1:0]     wr_ptr, rd_ptr, wr_idx;
  logic [7:0]        beat_cnt;
  logic [7:0]        head_len;
  logic              fifo_empty, rready, r_fire, len_hit, retire, rlast_bad;

  logic              rsp_valid_q, rsp_last_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic [1:0]        rsp_resp_q;
  logic [ID_W-1:0]   rsp_id_q;

  logic              tmo_flush, tmo_block;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
  endfunction

  // active_q keeps req_ready low while in reset and for the first edge after it
  always_ff @(posedge AClk or negedge ARst) begin
    if (!ARst) active_q <= 1'b0;
    else       active_q <= 1'b1;
  end

  // The length FIFO occupancy is exactly the outstanding count, so it also
  // provides the issue gate.
  assign bus.req_ready = active_q && (state_q == IDLE) && (outstanding < 5'(MAX_OUT));
  assign cmd_fire      = bus.req_valid && bus.req_ready;
  assign wrap_ok       = bus.req_len inside {8'd1, 8'd3, 8'd7, 8'd15};
  assign cmd_bad       = ((bus.req_burst == 2'b10) && !wrap_ok) || (bus.req_burst == 2'b11);
  assign ar_fire       = (state_q == ISSUE) && bus.ARREADY;

  always_ff @(posedge AClk or negedge ARst) begin
    if (!ARst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    load_ar  = 1'b0;
    drop_cmd = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          if (cmd_bad) begin
            drop_cmd = 1'b1;
          end else begin
            load_ar = 1'b1;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (bus.ARREADY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge AClk or negedge ARst) begin
    if (!ARst) begin
      ar_id_q    <= '0;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
      ar_lock_q  <= '0;
      ar_cache_q <= '0;
      ar_prot_q  <= '0;
      err_req    <= 1'b0;
    end else begin
      err_req <= drop_cmd;
      if (load_ar) begin
        ar_id_q    <= bus.req_id;
        ar_addr_q  <= bus.req_addr;
        ar_len_q   <= bus.req_len;
        ar_size_q  <= bus.req_size;
        ar_burst_q <= bus.req_burst;
        ar_lock_q  <= bus.req_lock;
        ar_cache_q <= bus.req_cache;
        ar_prot_q  <= bus.req_prot;
      end
    end
  end

  assign bus.ARVALID = (state_q == ISSUE);
  assign bus.ARID    = ar_id_q;
  assign bus.ARADDR  = ar_addr_q;
  assign bus.ARLEN   = ar_len_q;
  assign bus.ARSIZE  = ar_size_q;
  assign bus.ARBURST = ar_burst_q;
  assign bus.ARLOCK  = ar_lock_q;
  assign bus.ARCACHE = ar_cache_q;
  assign bus.ARPROT  = ar_prot_q;

  // A burst retires on RLAST or on reaching its expected length, whichever
  // comes first; any disagreement between the two is an RLAST error.
  assign fifo_empty = (outstanding == 5'd0);
  assign head_len   = len_mem[rd_ptr];
  assign rready     = !fifo_empty && (!rsp_valid_q || bus.rsp_ready) && !tmo_block;
  assign r_fire     = bus.RVALID && rready;
  assign len_hit    = (beat_cnt == head_len);
  assign retire     = r_fire && (bus.RLAST || len_hit);
  assign rlast_bad  = r_fire && (bus.RLAST != len_hit);
  assign bus.RREADY = rready;

  // A flush restarts the FIFO at slot 0, so a same-cycle push lands there.
  assign wr_idx = tmo_flush ? '0 : wr_ptr;

  always_ff @(posedge AClk) begin
    if (ar_fire) len_mem[wr_idx] <= ar_len_q;
  end

  always_ff @(posedge AClk or negedge ARst) begin
    if (!ARst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      beat_cnt    <= '0;
      outstanding <= '0;
    end else if (tmo_flush) begin
      rd_ptr      <= '0;
      beat_cnt    <= '0;
      wr_ptr      <= ar_fire ? ptr_inc('0) : '0;
      outstanding <= ar_fire ? 5'd1 : 5'd0;
    end else begin
      if (ar_fire) wr_ptr <= ptr_inc(wr_ptr);
      if (retire) begin
        rd_ptr   <= ptr_inc(rd_ptr);
        beat_cnt <= '0;
      end else if (r_fire) begin
        beat_cnt <= beat_cnt + 8'd1;
      end
      case ({ar_fire, retire})
        2'b10:   outstanding <= outstanding + 5'd1;
        2'b01:   outstanding <= outstanding - 5'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge AClk or negedge ARst) begin
    if (!ARst) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_resp_q  <= '0;
      rsp_id_q    <= '0;
      rsp_last_q  <= 1'b0;
    end else if (r_fire) begin
      rsp_valid_q <= 1'b1;
      rsp_data_q  <= bus.RDATA;
      rsp_resp_q  <= bus.RRESP;
      rsp_id_q    <= bus.RID;
      rsp_last_q  <= bus.RLAST || len_hit;
    end else if (bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_resp  = rsp_resp_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_last  = rsp_last_q;

  // A same-cycle error set wins over err_clr.
  always_ff @(posedge AClk or negedge ARst) begin
    if (!ARst)          err_rlast <= 1'b0;
    else if (rlast_bad) err_rlast <= 1'b1;
    else if (err_clr)   err_rlast <= 1'b0;
  end

`ifdef RD_TIMEOUT_EN
  logic [15:0] wdog;
  logic        tmo_block_q;

  // The watchdog fires on the TMO_CYC-th consecutive stalled cycle.
  assign tmo_flush = !fifo_empty && !r_fire && (wdog == 16'(TMO_CYC - 1));
  assign tmo_block = tmo_block_q;

  always_ff @(posedge AClk or negedge ARst) begin
    if (!ARst) begin
      wdog        <= '0;
      tmo_block_q <= 1'b0;
      err_tmo     <= 1'b0;
    end else begin
      tmo_block_q <= tmo_flush;
      if (tmo_flush || fifo_empty || r_fire) wdog <= '0;
      else                                   wdog <= wdog + 16'd1;
      if (tmo_flush)    err_tmo <= 1'b1;
      else if (err_clr) err_tmo <= 1'b0;
    end
  end
`else
  assign tmo_flush = 1'b0;
  assign tmo_block = 1'b0;
`endif

endmodule

// File: tb/tb_axi_master_rd_burst_engine.sv
// -----------------------------------------------------------------------------
// tb_axi_master_rd_burst_engine
// Directed testbench for axi_master_rd_burst_engine (default build, MAX_OUT=4).
// Drives the decoder, AR slave and R slave sides through the interface and
// compares outputs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_axi_master_rd_burst_engine;

  logic       AClk = 1'b0;
  logic       ARst = 1'b0;
  logic [4:0] outstanding;
  logic       err_req;
  logic       err_rlast;
  logic       err_clr;

  int nVec  = 0;
  int nMis  = 0;
  int arHs  = 0;
  int rspHs = 0;
  int base;

  axi_master_rd_burst_engine_if #(.ADDR_W(32), .DATA_W(64), .ID_W(4)) bus ();

  axi_master_rd_burst_engine #(.ADDR_W(32), .DATA_W(64), .ID_W(4), .MAX_OUT(4)) dut (
    .AClk        (AClk),
    .ARst        (ARst),
    .bus         (bus),
    .outstanding (outstanding),
    .err_req     (err_req),
    .err_rlast   (err_rlast),
    .err_clr     (err_clr)
  );

  // 100 MHz clock
  always #5 AClk = ~AClk;

  // Count AR and rsp handshakes; inputs only change just after posedge, so the
  // negedge values are the ones the next posedge will see.
  always @(negedge AClk) begin
    if (ARst && bus.ARVALID && bus.ARREADY) arHs++;
    if (ARst && bus.rsp_valid && bus.rsp_ready) rspHs++;
  end

  // Hard stop in case something hangs outside the bounded waits
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  task automatic tick();
    @(posedge AClk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nVec++;
    if (obs !== exp) begin
      nMis++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one command and hold it until accepted (bounded)
  task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] id,
                               input logic [7:0] len, input logic [1:0] burst);
    int n;
    bus.req_addr  = addr;
    bus.req_id    = id;
    bus.req_len   = len;
    bus.req_size  = 3'd3;
    bus.req_burst = burst;
    bus.req_lock  = 2'b01;
    bus.req_cache = 4'ha;
    bus.req_prot  = 3'b010;
    bus.req_valid = 1'b1;
    #1;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      tick();
      n++;
    end
    if (!bus.req_ready) checkOutput("req_ready_wait", 64'(0), 64'(1));
    else tick();
    bus.req_valid = 1'b0;
  endtask

  // Present one R beat and hold it until accepted (bounded); RVALID stays high
  task automatic sendBeat(input logic [63:0] data, input logic last, input logic [3:0] id);
    int n;
    bus.RVALID = 1'b1;
    bus.RDATA  = data;
    bus.RLAST  = last;
    bus.RID    = id;
    bus.RRESP  = 2'b00;
    #1;
    n = 0;
    while (!bus.RREADY && n < 20) begin
      tick();
      n++;
    end
    if (!bus.RREADY) checkOutput("rready_wait", 64'(0), 64'(1));
    else tick();
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_id    = '0;
    bus.req_len   = '0;
    bus.req_size  = '0;
    bus.req_burst = '0;
    bus.req_lock  = '0;
    bus.req_cache = '0;
    bus.req_prot  = '0;
    bus.ARREADY   = 1'b1;
    bus.RDATA     = '0;
    bus.RRESP     = '0;
    bus.RID       = '0;
    bus.RLAST     = 1'b0;
    bus.RVALID    = 1'b0;
    bus.rsp_ready = 1'b1;
    err_clr       = 1'b0;

    // Reset state
    repeat (3) tick();
    checkOutput("rst_arvalid", 64'(bus.ARVALID), 64'(0));
    checkOutput("rst_req_ready", 64'(bus.req_ready), 64'(0));
    checkOutput("rst_rready", 64'(bus.RREADY), 64'(0));
    checkOutput("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    checkOutput("rst_outstanding", 64'(outstanding), 64'(0));
    checkOutput("rst_err_req", 64'(err_req), 64'(0));
    checkOutput("rst_err_rlast", 64'(err_rlast), 64'(0));
    ARst = 1'b1;
    tick();
    tick();

    // INCR len=3, four beats with RLAST on the fourth
    $display("[TB] incr burst len 3");
    applyStimulus(32'h0000_1000, 4'h3, 8'd3, 2'b01);
    checkOutput("t1_arvalid", 64'(bus.ARVALID), 64'(1));
    checkOutput("t1_arlen", 64'(bus.ARLEN), 64'(3));
    checkOutput("t1_araddr", 64'(bus.ARADDR), 64'h1000);
    checkOutput("t1_arid", 64'(bus.ARID), 64'(3));
    checkOutput("t1_arattr", 64'({bus.ARSIZE, bus.ARBURST, bus.ARLOCK, bus.ARCACHE, bus.ARPROT}),
                64'({3'd3, 2'b01, 2'b01, 4'ha, 3'b010}));
    checkOutput("t1_req_ready_issue", 64'(bus.req_ready), 64'(0));
    tick();
    checkOutput("t1_outstanding_1", 64'(outstanding), 64'(1));
    checkOutput("t1_arvalid_clr", 64'(bus.ARVALID), 64'(0));
    for (int i = 0; i < 4; i++) begin
      sendBeat(64'hA000 + 64'(i), (i == 3), 4'h3);
      checkOutput("t1_rsp_valid", 64'(bus.rsp_valid), 64'(1));
      checkOutput("t1_rsp_data", bus.rsp_data, 64'hA000 + 64'(i));
      checkOutput("t1_rsp_last", 64'(bus.rsp_last), 64'(i == 3));
      checkOutput("t1_rsp_id", 64'(bus.rsp_id), 64'(3));
    end
    bus.RVALID = 1'b0;
    checkOutput("t1_outstanding_0", 64'(outstanding), 64'(0));
    checkOutput("t1_err_rlast", 64'(err_rlast), 64'(0));
    tick();
    checkOutput("t1_rsp_valid_drop", 64'(bus.rsp_valid), 64'(0));

    // Four back-to-back commands fill the tracker
    $display("[TB] four outstanding bursts");
    base = arHs;
    for (int k = 0; k < 4; k++) applyStimulus(32'h2000 + 32'(k * 64), 4'(k), 8'd0, 2'b01);
    tick();
    checkOutput("t2_ar_handshakes", 64'(arHs - base), 64'(4));
    checkOutput("t2_outstanding_4", 64'(outstanding), 64'(4));
    checkOutput("t2_req_ready_full", 64'(bus.req_ready), 64'(0));
    sendBeat(64'hB0, 1'b1, 4'h0);
    bus.RVALID = 1'b0;
    checkOutput("t2_outstanding_3", 64'(outstanding), 64'(3));
    checkOutput("t2_req_ready_free", 64'(bus.req_ready), 64'(1));
    checkOutput("t2_rsp_last", 64'(bus.rsp_last), 64'(1));
    for (int k = 1; k < 4; k++) begin
      sendBeat(64'hB0 + 64'(k), 1'b1, 4'(k));
      checkOutput("t2_rsp_id", 64'(bus.rsp_id), 64'(k));
    end
    bus.RVALID = 1'b0;
    checkOutput("t2_outstanding_0", 64'(outstanding), 64'(0));

    // Illegal WRAP length is dropped, legal one issues (with ARREADY stall)
    $display("[TB] wrap length checks");
    base = arHs;
    applyStimulus(32'h0000_3000, 4'h4, 8'd5, 2'b10);
    checkOutput("t3_err_req_pulse", 64'(err_req), 64'(1));
    checkOutput("t3_no_arvalid", 64'(bus.ARVALID), 64'(0));
    tick();
    checkOutput("t3_err_req_clr", 64'(err_req), 64'(0));
    checkOutput("t3_outstanding_0", 64'(outstanding), 64'(0));
    checkOutput("t3_no_ar_hs", 64'(arHs - base), 64'(0));
    bus.ARREADY = 1'b0;
    applyStimulus(32'h0000_3008, 4'h5, 8'd7, 2'b10);
    checkOutput("t3_wrap_arvalid", 64'(bus.ARVALID), 64'(1));
    checkOutput("t3_wrap_arlen", 64'(bus.ARLEN), 64'(7));
    checkOutput("t3_wrap_arburst", 64'(bus.ARBURST), 64'(2));
    checkOutput("t3_err_req_ok", 64'(err_req), 64'(0));
    tick();
    tick();
    checkOutput("t3_arvalid_held", 64'(bus.ARVALID), 64'(1));
    checkOutput("t3_araddr_held", 64'(bus.ARADDR), 64'h3008);
    checkOutput("t3_outstanding_stall", 64'(outstanding), 64'(0));
    bus.ARREADY = 1'b1;
    tick();
    checkOutput("t3_outstanding_1", 64'(outstanding), 64'(1));
    checkOutput("t3_arvalid_clr", 64'(bus.ARVALID), 64'(0));
    for (int i = 0; i < 8; i++) sendBeat(64'hC000 + 64'(i), (i == 7), 4'h5);
    bus.RVALID = 1'b0;
    checkOutput("t3_wrap_done", 64'(outstanding), 64'(0));
    checkOutput("t3_wrap_last", 64'(bus.rsp_last), 64'(1));
    checkOutput("t3_wrap_err_rlast", 64'(err_rlast), 64'(0));

    // Early RLAST: len=3 but RLAST on beat 2
    $display("[TB] rlast mismatch");
    applyStimulus(32'h0000_4000, 4'h6, 8'd3, 2'b01);
    tick();
    sendBeat(64'hD0, 1'b0, 4'h6);
    checkOutput("t4_no_err_yet", 64'(err_rlast), 64'(0));
    sendBeat(64'hD1, 1'b1, 4'h6);
    bus.RVALID = 1'b0;
    checkOutput("t4_err_rlast_early", 64'(err_rlast), 64'(1));
    checkOutput("t4_retired_early", 64'(outstanding), 64'(0));
    checkOutput("t4_rsp_last_early", 64'(bus.rsp_last), 64'(1));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checkOutput("t4_err_clr", 64'(err_rlast), 64'(0));

    // Missing RLAST: len=1, two beats without RLAST; err_clr during the set
    applyStimulus(32'h0000_4100, 4'h6, 8'd1, 2'b01);
    tick();
    sendBeat(64'hD2, 1'b0, 4'h6);
    checkOutput("t4_mid_last", 64'(bus.rsp_last), 64'(0));
    err_clr = 1'b1;
    sendBeat(64'hD3, 1'b0, 4'h6);
    err_clr = 1'b0;
    bus.RVALID = 1'b0;
    checkOutput("t4_err_set_wins", 64'(err_rlast), 64'(1));
    checkOutput("t4_forced_last", 64'(bus.rsp_last), 64'(1));
    checkOutput("t4_retired_len", 64'(outstanding), 64'(0));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checkOutput("t4_err_clr2", 64'(err_rlast), 64'(0));

    // Response back-pressure for 5 cycles after the first beat
    $display("[TB] rsp back-pressure");
    base = rspHs;
    applyStimulus(32'h0000_5000, 4'h7, 8'd3, 2'b01);
    tick();
    bus.rsp_ready = 1'b0;
    sendBeat(64'hE0, 1'b0, 4'h7);
    bus.RDATA = 64'hE1;
    for (int c = 0; c < 5; c++) begin
      #1;
      checkOutput("t5_rready_low", 64'(bus.RREADY), 64'(0));
      checkOutput("t5_data_stable", bus.rsp_data, 64'hE0);
      tick();
    end
    checkOutput("t5_valid_held", 64'(bus.rsp_valid), 64'(1));
    bus.rsp_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      sendBeat(64'hE0 + 64'(i), (i == 3), 4'h7);
      checkOutput("t5_rsp_data", bus.rsp_data, 64'hE0 + 64'(i));
    end
    bus.RVALID = 1'b0;
    checkOutput("t5_rsp_last", 64'(bus.rsp_last), 64'(1));
    tick();
    checkOutput("t5_rsp_count", 64'(rspHs - base), 64'(4));
    checkOutput("t5_outstanding_0", 64'(outstanding), 64'(0));

    // Reset in the middle of an 8-beat burst, then a fresh single-beat read
    $display("[TB] reset mid-burst");
    applyStimulus(32'h0000_6000, 4'h9, 8'd7, 2'b01);
    tick();
    sendBeat(64'hF0, 1'b0, 4'h9);
    sendBeat(64'hF1, 1'b0, 4'h9);
    ARst = 1'b0;
    #1;
    checkOutput("t6_rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    checkOutput("t6_rst_rsp_data", bus.rsp_data, 64'(0));
    checkOutput("t6_rst_rready", 64'(bus.RREADY), 64'(0));
    checkOutput("t6_rst_outstanding", 64'(outstanding), 64'(0));
    checkOutput("t6_rst_req_ready", 64'(bus.req_ready), 64'(0));
    base = rspHs;
    tick();
    tick();
    checkOutput("t6_rst_no_rsp", 64'(rspHs - base), 64'(0));
    checkOutput("t6_rst_still_idle", 64'(bus.rsp_valid), 64'(0));
    bus.RVALID = 1'b0;
    ARst = 1'b1;
    tick();
    tick();
    applyStimulus(32'h0000_7000, 4'h2, 8'd0, 2'b01);
    checkOutput("t6_new_arlen", 64'(bus.ARLEN), 64'(0));
    tick();
    checkOutput("t6_new_outstanding", 64'(outstanding), 64'(1));
    sendBeat(64'h99, 1'b1, 4'h2);
    bus.RVALID = 1'b0;
    checkOutput("t6_new_data", bus.rsp_data, 64'h99);
    checkOutput("t6_new_last", 64'(bus.rsp_last), 64'(1));
    checkOutput("t6_new_done", 64'(outstanding), 64'(0));
    checkOutput("t6_new_err", 64'(err_rlast), 64'(0));
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
